// File: rtl/lsu_ctrl_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// lsu_ctrl_pkg : encodings shared by the MEM-stage load/store unit
// Rev 1.0
// -----------------------------------------------------------------------------
package lsu_ctrl_pkg;

  localparam logic [6:0] INSTR_LD = 7'b0000011;
  localparam logic [6:0] INSTR_ST = 7'b0100011;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } lsu_state_e;

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// -----------------------------------------------------------------------------
// lsu_align : size decode, byte strobes, store lane placement, load extension
// Rev 1.0
// -----------------------------------------------------------------------------
module lsu_align
  import lsu_ctrl_pkg::*;
#(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic        misalign_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ld_data_o
);

  logic [4:0]  sh;
  logic [15:0] lo16;
  logic [31:0] rep;
  logic        sext;

  always_comb begin
    sh         = {addr_lo_i, 3'b000};
    lo16       = 16'(rdata_i >> sh);
    sext       = ~funct3_i[2];
    misalign_o = 1'b0;
    be_o       = 4'b0000;
    rep        = '0;
    ld_data_o  = '0;
    case (funct3_i)
      LSU_B, LSU_BU: begin
        be_o      = 4'b0001 << addr_lo_i;
        rep       = {4{wdata_i[7:0]}};
        ld_data_o = {{24{sext & lo16[7]}}, lo16[7:0]};
      end
      LSU_H, LSU_HU: begin
        misalign_o = CHECK_ALIGN & addr_lo_i[0];
        be_o       = 4'b0011 << addr_lo_i;
        rep        = {2{wdata_i[15:0]}};
        ld_data_o  = {{16{sext & lo16[15]}}, lo16};
      end
      LSU_W: begin
        misalign_o = CHECK_ALIGN & (addr_lo_i != 2'b00);
        be_o       = 4'b1111;
        rep        = wdata_i;
        ld_data_o  = rdata_i;
      end
      // Unencoded widths are reported through the misalign path.
      default: misalign_o = 1'b1;
    endcase
    // Rotate rather than shift so unaligned sizes still land in their lanes.
    wdata_o = (rep << sh) | (rep >> (6'd32 - {1'b0, sh}));
  end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// lsu_ctrl : RV32 MEM-stage load/store unit, handshaked data-bus master
// Rev 1.0
// -----------------------------------------------------------------------------
module lsu_ctrl
  import lsu_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter bit          CHECK_ALIGN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_st_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [4:0]        req_rd_idx_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_gnt_i,
  input  logic              bus_rvalid_i,
  input  logic [31:0]       bus_rdata_i,
  input  logic              bus_err_i,
  output logic              rsp_valid_o,
  output logic              rsp_rd_en_o,
  output logic [4:0]        rsp_rd_idx_o,
  output logic [31:0]       rsp_rd_wdata_o,
  output logic              excp_ld_misalign_o,
  output logic              excp_ld_bus_err_o,
  output logic              excp_st_amo_misalign_o,
  output logic              excp_st_amo_bus_err_o,
  output logic [ADDR_W-1:0] excp_bad_addr_o
);

  localparam int unsigned      CNT_W    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_e        state_q, state_d;
  logic              st_q, st_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [4:0]        rd_idx_q, rd_idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [3:0]        bus_be_q, bus_be_d;
  logic [31:0]       bus_wdata_q, bus_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_rd_en_q, rsp_rd_en_d;
  logic [4:0]        rsp_rd_idx_q, rsp_rd_idx_d;
  logic [31:0]       rsp_rd_wdata_q, rsp_rd_wdata_d;
  logic [3:0]        excp_q, excp_d;
  logic [ADDR_W-1:0] bad_addr_q, bad_addr_d;

  logic              in_idle;
  logic [2:0]        al_funct3;
  logic [1:0]        al_addr_lo;
  logic              al_misalign;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_ld;
  logic              timeout;
  logic              go_rsp;
  logic              rsp_fault;
  logic              rsp_mis;
  logic              ld_ok;

  // Align unit sees the incoming request in IDLE and the captured op otherwise.
  assign in_idle    = (state_q == S_IDLE);
  assign al_funct3  = in_idle ? req_funct3_i : funct3_q;
  assign al_addr_lo = in_idle ? req_addr_i[1:0] : addr_q[1:0];
  assign timeout    = (TIMEOUT_CYC != 0) && (cnt_q == CNT_LAST);

  lsu_align #(
    .CHECK_ALIGN (CHECK_ALIGN)
  ) u_align (
    .funct3_i   (al_funct3),
    .addr_lo_i  (al_addr_lo),
    .wdata_i    (req_wdata_i),
    .rdata_i    (bus_rdata_i),
    .misalign_o (al_misalign),
    .be_o       (al_be),
    .wdata_o    (al_wdata),
    .ld_data_o  (al_ld)
  );

  always_comb begin
    state_d     = state_q;
    st_d        = st_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    rd_idx_d    = rd_idx_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_be_d    = bus_be_q;
    bus_wdata_d = bus_wdata_q;
    go_rsp      = 1'b0;
    rsp_fault   = 1'b0;
    rsp_mis     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          st_d     = req_st_i;
          funct3_d = req_funct3_i;
          addr_d   = req_addr_i;
          rd_idx_d = req_rd_idx_i;
          cnt_d    = '0;
          if (al_misalign) begin
            go_rsp  = 1'b1;
            rsp_mis = 1'b1;
          end else begin
            state_d     = S_REQ;
            bus_req_d   = 1'b1;
            bus_we_d    = req_st_i;
            bus_addr_d  = {req_addr_i[ADDR_W-1:2], 2'b00};
            bus_be_d    = al_be;
            bus_wdata_d = al_wdata;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (timeout) begin
          go_rsp    = 1'b1;
          rsp_fault = 1'b1;
        end else if (bus_gnt_i) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (bus_rvalid_i) begin
          go_rsp    = 1'b1;
          rsp_fault = bus_err_i;
        end else if (timeout) begin
          go_rsp    = 1'b1;
          rsp_fault = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (go_rsp) begin
      state_d = S_RESP;
    end
    if (state_d != S_REQ) begin
      bus_req_d   = 1'b0;
      bus_we_d    = 1'b0;
      bus_addr_d  = '0;
      bus_be_d    = 4'b0000;
      bus_wdata_d = '0;
    end

    ld_ok          = go_rsp & ~st_d & ~rsp_fault & ~rsp_mis;
    ready_d        = (state_d == S_IDLE);
    rsp_valid_d    = go_rsp;
    rsp_rd_en_d    = ld_ok & (rd_idx_d != 5'd0);
    rsp_rd_idx_d   = go_rsp ? rd_idx_d : 5'd0;
    rsp_rd_wdata_d = ld_ok ? al_ld : 32'd0;
    excp_d         = {rsp_mis & ~st_d, rsp_fault & ~st_d, rsp_mis & st_d, rsp_fault & st_d};
    bad_addr_d     = (rsp_mis | rsp_fault) ? addr_d : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      st_q           <= 1'b0;
      funct3_q       <= 3'b000;
      addr_q         <= '0;
      rd_idx_q       <= 5'd0;
      cnt_q          <= '0;
      ready_q        <= 1'b1;
      bus_req_q      <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= '0;
      bus_be_q       <= 4'b0000;
      bus_wdata_q    <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_rd_en_q    <= 1'b0;
      rsp_rd_idx_q   <= 5'd0;
      rsp_rd_wdata_q <= '0;
      excp_q         <= 4'b0000;
      bad_addr_q     <= '0;
    end else begin
      state_q        <= state_d;
      st_q           <= st_d;
      funct3_q       <= funct3_d;
      addr_q         <= addr_d;
      rd_idx_q       <= rd_idx_d;
      cnt_q          <= cnt_d;
      ready_q        <= ready_d;
      bus_req_q      <= bus_req_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_be_q       <= bus_be_d;
      bus_wdata_q    <= bus_wdata_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_rd_en_q    <= rsp_rd_en_d;
      rsp_rd_idx_q   <= rsp_rd_idx_d;
      rsp_rd_wdata_q <= rsp_rd_wdata_d;
      excp_q         <= excp_d;
      bad_addr_q     <= bad_addr_d;
    end
  end

  assign req_ready_o            = ready_q;
  assign bus_req_o              = bus_req_q;
  assign bus_we_o               = bus_we_q;
  assign bus_addr_o             = bus_addr_q;
  assign bus_be_o               = bus_be_q;
  assign bus_wdata_o            = bus_wdata_q;
  assign rsp_valid_o            = rsp_valid_q;
  assign rsp_rd_en_o            = rsp_rd_en_q;
  assign rsp_rd_idx_o           = rsp_rd_idx_q;
  assign rsp_rd_wdata_o         = rsp_rd_wdata_q;
  assign excp_ld_misalign_o     = excp_q[3];
  assign excp_ld_bus_err_o      = excp_q[2];
  assign excp_st_amo_misalign_o = excp_q[1];
  assign excp_st_amo_bus_err_o  = excp_q[0];
  assign excp_bad_addr_o        = bad_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_lsu_ctrl : directed scoreboard bench for the load/store unit
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_st_i = 1'b0;
  logic [2:0]  req_funct3_i = 3'b000;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic [4:0]  req_rd_idx_i = '0;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [31:0] bus_addr_o;
  logic [3:0]  bus_be_o;
  logic [31:0] bus_wdata_o;
  logic        bus_gnt_i = 1'b0;
  logic        bus_rvalid_i = 1'b0;
  logic [31:0] bus_rdata_i = '0;
  logic        bus_err_i = 1'b0;
  logic        rsp_valid_o;
  logic        rsp_rd_en_o;
  logic [4:0]  rsp_rd_idx_o;
  logic [31:0] rsp_rd_wdata_o;
  logic        excp_ld_misalign_o;
  logic        excp_ld_bus_err_o;
  logic        excp_st_amo_misalign_o;
  logic        excp_st_amo_bus_err_o;
  logic [31:0] excp_bad_addr_o;

  always #5 clk = ~clk;

  lsu_ctrl #(
    .ADDR_W      (32),
    .TIMEOUT_CYC (64),
    .CHECK_ALIGN (1'b1)
  ) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .req_valid_i            (req_valid_i),
    .req_ready_o            (req_ready_o),
    .req_st_i               (req_st_i),
    .req_funct3_i           (req_funct3_i),
    .req_addr_i             (req_addr_i),
    .req_wdata_i            (req_wdata_i),
    .req_rd_idx_i           (req_rd_idx_i),
    .bus_req_o              (bus_req_o),
    .bus_we_o               (bus_we_o),
    .bus_addr_o             (bus_addr_o),
    .bus_be_o               (bus_be_o),
    .bus_wdata_o            (bus_wdata_o),
    .bus_gnt_i              (bus_gnt_i),
    .bus_rvalid_i           (bus_rvalid_i),
    .bus_rdata_i            (bus_rdata_i),
    .bus_err_i              (bus_err_i),
    .rsp_valid_o            (rsp_valid_o),
    .rsp_rd_en_o            (rsp_rd_en_o),
    .rsp_rd_idx_o           (rsp_rd_idx_o),
    .rsp_rd_wdata_o         (rsp_rd_wdata_o),
    .excp_ld_misalign_o     (excp_ld_misalign_o),
    .excp_ld_bus_err_o      (excp_ld_bus_err_o),
    .excp_st_amo_misalign_o (excp_st_amo_misalign_o),
    .excp_st_amo_bus_err_o  (excp_st_amo_bus_err_o),
    .excp_bad_addr_o        (excp_bad_addr_o)
  );

  typedef struct {
    logic        rd_en;
    logic [31:0] rdata;
    logic [4:0]  rd_idx;
    logic [3:0]  excp;
    logic [31:0] bad;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem[int];
  int          n_checks = 0;
  int          n_err = 0;

  function automatic logic [3:0] excp_vec();
    return {excp_ld_misalign_o, excp_ld_bus_err_o, excp_st_amo_misalign_o, excp_st_amo_bus_err_o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One complete transaction: drive, act as bus slave, pop scoreboard on response.
  task automatic do_op(input string tag, input logic st, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                       input int gdly, input int rdly, input logic err,
                       input logic exp_bus, input logic [3:0] exp_be, input logic [31:0] exp_bwd,
                       input logic [31:0] exp_rdata, input logic [3:0] exp_excp, input int exp_lat);
    exp_t        e;
    int          phase;
    int          cnt;
    int          idx;
    logic        got;
    logic        saw_bus;
    logic [3:0]  cap_be;
    logic [31:0] cap_wd;
    logic [31:0] w;
    e.rd_en  = !st && (exp_excp == 4'b0000) && (rd != 5'd0);
    e.rdata  = exp_rdata;
    e.rd_idx = rd;
    e.excp   = exp_excp;
    e.bad    = (exp_excp != 4'b0000) ? addr : 32'h0;
    e.lat    = exp_lat;
    sb.push_back(e);
    idx     = int'(addr >> 2);
    phase   = 0;
    cnt     = 0;
    got     = 1'b0;
    saw_bus = 1'b0;
    cap_be  = '0;
    cap_wd  = '0;
    @(negedge clk);
    chk({tag, ".ready"}, {31'd0, req_ready_o}, 32'd1);
    req_valid_i  = 1'b1;
    req_st_i     = st;
    req_funct3_i = f3;
    req_addr_i   = addr;
    req_wdata_i  = wd;
    req_rd_idx_i = rd;
    for (int cyc = 1; cyc <= 150 && !got; cyc++) begin
      @(negedge clk);
      req_valid_i  = 1'b0;
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      bus_err_i    = 1'b0;
      if (rsp_valid_o) begin
        got = 1'b1;
        e = sb.pop_front();
        chk({tag, ".lat"}, cyc, e.lat);
        chk({tag, ".rd_en"}, {31'd0, rsp_rd_en_o}, {31'd0, e.rd_en});
        chk({tag, ".rd_wdata"}, rsp_rd_wdata_o, e.rdata);
        if (e.rd_en) chk({tag, ".rd_idx"}, {27'd0, rsp_rd_idx_o}, {27'd0, e.rd_idx});
        chk({tag, ".excp"}, {28'd0, excp_vec()}, {28'd0, e.excp});
        chk({tag, ".bad_addr"}, excp_bad_addr_o, e.bad);
      end else if (phase == 0 && bus_req_o) begin
        if (!saw_bus) begin
          saw_bus = 1'b1;
          cap_be  = bus_be_o;
          cap_wd  = bus_wdata_o;
          chk({tag, ".bus_we"}, {31'd0, bus_we_o}, {31'd0, st});
          chk({tag, ".bus_addr"}, bus_addr_o, {addr[31:2], 2'b00});
          chk({tag, ".bus_be"}, {28'd0, bus_be_o}, {28'd0, exp_be});
          if (st) chk({tag, ".bus_wdata"}, bus_wdata_o, exp_bwd);
        end
        if (cnt == gdly) begin
          bus_gnt_i = 1'b1;
          phase     = 1;
          cnt       = 0;
        end else begin
          cnt++;
        end
      end else if (phase == 1) begin
        if (cnt == rdly) begin
          w            = mem.exists(idx) ? mem[idx] : 32'h0;
          bus_rvalid_i = 1'b1;
          bus_err_i    = err;
          bus_rdata_i  = w;
          if (st && !err) begin
            for (int b = 0; b < 4; b++) if (cap_be[b]) w[8*b +: 8] = cap_wd[8*b +: 8];
            mem[idx] = w;
          end
          phase = 2;
        end else begin
          cnt++;
        end
      end
    end
    bus_gnt_i    = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_err_i    = 1'b0;
    if (!got) begin
      n_checks++;
      n_err++;
      $display("FAIL %s.rsp_timeout: observed=no rsp_valid expected=rsp_valid", tag);
      void'(sb.pop_front());
    end
    chk({tag, ".bus_seen"}, {31'd0, saw_bus}, {31'd0, exp_bus});
    @(negedge clk);
    chk({tag, ".rsp_pulse"}, {31'd0, rsp_valid_o}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=no finish expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst.ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst.bus_req", {31'd0, bus_req_o}, 32'd0);
    chk("rst.rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("rst.excp", {28'd0, excp_vec()}, 32'd0);
    chk("rst.bus_be", {28'd0, bus_be_o}, 32'd0);
    chk("rst.rd_wdata", rsp_rd_wdata_o, 32'd0);
    rst_n = 1'b1;

    // Loads and sign/zero extension
    mem[32'h40] = 32'h8899AABB;
    do_op("lw100", 1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 0, 0, 1'b0, 1'b1, 4'hF, 32'h0, 32'h8899AABB, 4'h0, 3);
    mem[32'h40] = 32'h80000000;
    do_op("lb103", 1'b0, 3'b000, 32'h103, 32'h0, 5'd6, 0, 0, 1'b0, 1'b1, 4'h8, 32'h0, 32'hFFFFFF80, 4'h0, 3);
    do_op("lbu103", 1'b0, 3'b100, 32'h103, 32'h0, 5'd7, 0, 1, 1'b0, 1'b1, 4'h8, 32'h0, 32'h00000080, 4'h0, 4);
    mem[32'h40] = 32'h80010000;
    do_op("lh102", 1'b0, 3'b001, 32'h102, 32'h0, 5'd8, 0, 0, 1'b0, 1'b1, 4'hC, 32'h0, 32'hFFFF8001, 4'h0, 3);
    do_op("lhu102", 1'b0, 3'b101, 32'h102, 32'h0, 5'd9, 0, 0, 1'b0, 1'b1, 4'hC, 32'h0, 32'h00008001, 4'h0, 3);
    do_op("lb_x0", 1'b0, 3'b000, 32'h100, 32'h0, 5'd0, 0, 0, 1'b0, 1'b1, 4'h1, 32'h0, 32'h00000000, 4'h0, 3);

    // Stores with strobes, merged read-back, wait states
    mem[32'h80] = 32'h11223344;
    do_op("sb201", 1'b1, 3'b000, 32'h201, 32'h000000A5, 5'd0, 0, 2, 1'b0, 1'b1, 4'h2, 32'hA5A5A5A5, 32'h0, 4'h0, 5);
    do_op("lw200a", 1'b0, 3'b010, 32'h200, 32'h0, 5'd10, 0, 0, 1'b0, 1'b1, 4'hF, 32'h0, 32'h1122A544, 4'h0, 3);
    do_op("sh202", 1'b1, 3'b001, 32'h202, 32'h1234BEEF, 5'd0, 3, 0, 1'b0, 1'b1, 4'hC, 32'hBEEFBEEF, 32'h0, 4'h0, 6);
    do_op("lw200b", 1'b0, 3'b010, 32'h200, 32'h0, 5'd11, 0, 0, 1'b0, 1'b1, 4'hF, 32'h0, 32'hBEEFA544, 4'h0, 3);
    do_op("lh202", 1'b0, 3'b001, 32'h202, 32'h0, 5'd12, 1, 1, 1'b0, 1'b1, 4'hC, 32'h0, 32'hFFFFBEEF, 4'h0, 5);

    // Misalignment and illegal widths never reach the bus
    do_op("lh101", 1'b0, 3'b001, 32'h101, 32'h0, 5'd3, 0, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 4'b1000, 1);
    do_op("sw302", 1'b1, 3'b010, 32'h302, 32'h0, 5'd0, 0, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 4'b0010, 1);
    do_op("ld_f3_011", 1'b0, 3'b011, 32'h100, 32'h0, 5'd4, 0, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 4'b1000, 1);
    do_op("st_f3_111", 1'b1, 3'b111, 32'h300, 32'h0, 5'd0, 0, 0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 4'b0010, 1);

    // Bus error response
    do_op("lw_err", 1'b0, 3'b010, 32'h104, 32'h0, 5'd13, 0, 0, 1'b1, 1'b1, 4'hF, 32'h0, 32'h0, 4'b0100, 3);

    // Grant withheld past the timeout; 64 cycles in REQ, response the cycle after
    do_op("sw_tmo", 1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 5'd0, 70, 0, 1'b0, 1'b1, 4'hF, 32'hCAFEF00D, 32'h0, 4'b0001, 65);
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'hDEADBEEF;
    @(negedge clk);
    bus_rvalid_i = 1'b0;
    chk("late_rvalid.rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
    chk("late_rvalid.ready", {31'd0, req_ready_o}, 32'd1);
    do_op("lw_after_tmo", 1'b0, 3'b010, 32'h100, 32'h0, 5'd14, 0, 0, 1'b0, 1'b1, 4'hF, 32'h0, 32'h80010000, 4'h0, 3);

    // Reset while REQ: bus_req drops without a clock edge
    @(negedge clk);
    req_valid_i = 1'b1; req_st_i = 1'b0; req_funct3_i = 3'b010; req_addr_i = 32'h100; req_rd_idx_i = 5'd1;
    @(negedge clk);
    req_valid_i = 1'b0;
    chk("rst_req.bus_req_before", {31'd0, bus_req_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_req.bus_req_async", {31'd0, bus_req_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset while WAIT: outstanding response dropped
    @(negedge clk);
    req_valid_i = 1'b1;
    @(negedge clk);
    req_valid_i = 1'b0;
    bus_gnt_i   = 1'b1;
    @(negedge clk);
    bus_gnt_i = 1'b0;
    chk("rst_wait.ready_before", {31'd0, req_ready_o}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wait.ready", {31'd0, req_ready_o}, 32'd1);
    chk("rst_wait.bus_req", {31'd0, bus_req_o}, 32'd0);
    @(negedge clk);
    rst_n        = 1'b1;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h12345678;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_rvalid_i = 1'b0;
      chk("rst_wait.no_rsp", {31'd0, rsp_valid_o}, 32'd0);
    end
    chk("rst_wait.ready_after", {31'd0, req_ready_o}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
